// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings,
// controller state type and the access-size helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Byte-lane mask for an access; funct3[1:0] carries the size for both
    // signed and unsigned loads.
    function automatic logic [3:0] funct3_bmask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Stores only exist in signed-size form; loads reject the encodings
    // that RISC-V leaves undefined for RV32.
    function automatic logic funct3_invalid(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) begin
            bad = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end else begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the raw memory word according to the load funct3.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    // Select and extend the low byte/half or pass the whole word.
    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            F3_H:    data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {24'd0, rdata_i[7:0]};
            F3_HU:   data_o = {16'd0, rdata_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-requester load/store controller owning one port of the data memory.
// Round-robin arbitration, request capture, one memory access cycle and a
// one-cycle response; a grant may overlap the response cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | nothing in flight, grant allowed
// ST_ACCESS | captured request drives the memory port
// ST_RESP   | owner's rvalid asserted, another grant allowed
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [2:0]        i_a_funct3,
    input  logic [31:0]       i_a_addr,
    input  logic [31:0]       i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [31:0]       o_a_rdata,
    output logic              o_a_err,

    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [2:0]        i_b_funct3,
    input  logic [31:0]       i_b_addr,
    input  logic [31:0]       i_b_wdata,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [31:0]       o_b_rdata,
    output logic              o_b_err,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    state_e            state_q, state_d;
    // Last-granted pointer; since it moves on every grant it also names the
    // owner of the transaction currently in flight.
    logic              last_b_q, last_b_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              can_gnt;
    logic              gnt_a, gnt_b, gnt_any;
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       ext_data;
    logic [31:0]       resp_data;

    // Round-robin arbitration and selection of the winning request.
    always_comb begin
        can_gnt   = (state_q == ST_IDLE) || (state_q == ST_RESP);
        gnt_a     = can_gnt && i_a_req && (!i_b_req || last_b_q);
        gnt_b     = can_gnt && i_b_req && (!i_a_req || !last_b_q);
        gnt_any   = gnt_a || gnt_b;
        sel_we    = gnt_b ? i_b_we     : i_a_we;
        sel_f3    = gnt_b ? i_b_funct3 : i_a_funct3;
        sel_addr  = gnt_b ? i_b_addr   : i_a_addr;
        sel_wdata = gnt_b ? i_b_wdata  : i_a_wdata;
    end

    assign o_a_gnt = gnt_a;
    assign o_b_gnt = gnt_b;

    // Next state and capture of the granted request.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE:   if (gnt_any) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = gnt_any ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (gnt_any) begin
            last_b_d = gnt_b;
            we_d     = sel_we;
            f3_d     = sel_f3;
            addr_d   = sel_addr[ADDR_W-1:0];
            wdata_d  = sel_wdata;
            err_d    = (sel_addr[31:ADDR_W] != '0) || funct3_invalid(sel_we, sel_f3);
        end
    end

    // State, pointer and capture registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    mem_load_ext u_load_ext (
        .funct3_i (f3_q),
        .rdata_i  (i_mem_rdata),
        .data_o   (ext_data)
    );

    // Memory port during ACCESS, owner response during RESP, zero otherwise.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        o_mem_wren  = 1'b0;
        o_a_rvalid  = 1'b0;
        o_a_rdata   = '0;
        o_a_err     = 1'b0;
        o_b_rvalid  = 1'b0;
        o_b_rdata   = '0;
        o_b_err     = 1'b0;
        resp_data   = (we_q || err_q) ? 32'd0 : ext_data;

        if (state_q == ST_ACCESS) begin
            o_mem_addr  = addr_q;
            o_mem_wdata = wdata_q;
            o_mem_bmask = funct3_bmask(f3_q);
            o_mem_wren  = we_q && !err_q;
        end

        if (state_q == ST_RESP) begin
            if (last_b_q) begin
                o_b_rvalid = 1'b1;
                o_b_rdata  = resp_data;
                o_b_err    = err_q;
            end else begin
                o_a_rvalid = 1'b1;
                o_a_rdata  = resp_data;
                o_a_err    = err_q;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-requester load/store controller that owns port 1 of the byte-addressed data memory (synchronous read, byte-masked write, 1-cycle read latency). It arbitrates round-robin between the core LSU (requester A) and the loader/debug master (requester B). It decodes RISC-V funct3 into byte masks, sequences the access, and returns sign/zero-extended load data with a fixed two-cycle latency. It sits between EX/MEM pipeline logic and the memory instance; port 2 of the memory is not touched.

## Interface
- ADDR_W, 16, memory byte-address width; must match the memory instance.
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_a_req / i_b_req  in  1  request valid; held stable until granted
- i_a_we / i_b_we  in  1  1 = store, 0 = load
- i_a_funct3 / i_b_funct3  in  3  access size/sign (RISC-V load/store funct3)
- i_a_addr / i_b_addr  in  32  byte address
- i_a_wdata / i_b_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- o_a_gnt / o_b_gnt  out  1  request accepted this cycle (combinational)
- o_a_rvalid / o_b_rvalid  out  1  response valid, one-cycle pulse
- o_a_rdata / o_b_rdata  out  32  extended load data; 0 for stores and errors
- o_a_err / o_b_err  out  1  qualifies rvalid: bad funct3 or address out of range
- o_mem_addr  out  ADDR_W  memory byte address
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  byte-lane write enable
- o_mem_wren  out  1  memory write strobe
- i_mem_rdata  in  32  memory registered read data, valid one cycle after address

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE --grant--> ACCESS --> RESP.
  - RESP --grant--> ACCESS; otherwise RESP --> IDLE.
- Grants are possible only in IDLE or RESP. At most one grant per cycle.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active: the requester not granted most recently wins.
  - The last-granted pointer updates on every grant.
  - After reset the pointer points to B, so A wins the first tie.
- On grant, the request is captured into registers: owner, we, funct3, addr, wdata, and err.
- err is set when either of these holds:
  - addr[31:ADDR_W] ≠ 0
  - funct3 is invalid: loads 011/110/111; stores anything other than 000/001/010.
- In ACCESS:
  - o_mem_addr = captured addr[ADDR_W-1:0].
  - o_mem_wdata = captured wdata, unshifted.
  - o_mem_bmask: 0001 for byte, 0011 for half, 1111 for word.
  - o_mem_wren = we & ~err.
  - Misaligned addresses are legal. The memory handles byte-address wrap modulo 2^ADDR_W.
- In RESP:
  - The owner's rvalid = 1 and its err = captured err.
  - Load data:
    - 000: sign-extend i_mem_rdata[7:0].
    - 001: sign-extend i_mem_rdata[15:0].
    - 010: i_mem_rdata.
    - 100: zero-extend [7:0].
    - 101: zero-extend [15:0].
  - Stores and errors return 0.
- Memory outputs are 0 in IDLE and RESP (wren=0, bmask=0, addr=0, wdata=0).

## Timing
- Request granted in cycle N:
  - Memory access occurs in N+1; a store commits at the end of N+1.
  - Response is presented in N+2 (fixed latency 2).
- Back-to-back throughput: one access per 2 cycles, because a grant in RESP overlaps the response.
- A load issued in the RESP cycle of a store to the same bytes returns the new data, since the write commits before the load's ACCESS.
- Reset values: state IDLE; all o_* = 0; pointer = B.
- Reset asserted mid-transaction:
  - The transaction is dropped.
  - No rvalid is produced.
  - A store reaching ACCESS before reset has already written; the controller does no recovery.
- A request deasserted before grant is ignored with no side effects.

## Structure
- Package mem_access_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum typedef
  - a function mapping funct3 to bmask
- Sub-module mem_load_ext: combinational funct3-driven extension of i_mem_rdata. It is instantiated once.
- Arbiter, FSM and capture registers live in the top.

## Test plan
- A only, lw at 0x0010 after sw 0xDEADBEEF at 0x0010 -> rvalid at N+2 with rdata 0xDEADBEEF, err 0.
- A and B both requesting continuously -> grants alternate A,B,A,B; each rvalid goes to the correct owner 2 cycles after its grant.
- sb 0x80 at 0x0003, then lb and lbu at 0x0003 -> 0xFFFFFF80 and 0x00000080; neighbouring bytes unchanged.
- Misaligned sw 0x11223344 at 0xFFFE with ADDR_W=16, then lw at 0xFFFE -> 0x11223344 via wrap to 0x0000/0x0001.
- lw at 0x0001_0000 and store with funct3 100 -> err=1, rdata=0, o_mem_wren never asserted.
- Reset pulled low in the ACCESS cycle of a load -> no rvalid, all outputs 0; next request after release is granted to A.
